// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: multi-cycle ALU sequencing, branch squash,
// load-use bubbles and operand-forwarding selects for the two ALU source muxes.
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idValid,
  input  logic [3:0] idRq,
  input  logic [3:0] idRs,
  input  logic       idUsesRq,
  input  logic       idUsesRs,
  input  logic       exValid,
  input  logic [3:0] exRq,
  input  logic [3:0] exRs,
  input  logic [3:0] exRd,
  input  logic       exRegWrite,
  input  logic       exIsLoad,
  input  logic       exMultiCycle,
  input  logic       exFlush,
  input  logic [3:0] memRd,
  input  logic [3:0] wbRd,
  input  logic       memRegWrite,
  input  logic       wbRegWrite,
  output logic       stallIF,
  output logic       stallID,
  output logic       stallEX,
  output logic       bubbleEX,
  output logic       flushID,
  output logic [1:0] fwdA,
  output logic [1:0] fwdB,
  output logic       aluBusy,
  output logic       aluDone
);

  typedef enum logic [1:0] {RUN, MULTI, REDIRECT} state_t;

  // The RUN cycle is the first of MUL_LAT, so MULTI counts MUL_LAT-2 down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic [3:0] mem_rd,
    input logic       mem_we,
    input logic [3:0] wb_rd,
    input logic       wb_we
  );
    if (mem_we && (mem_rd != 4'd0) && (mem_rd == src))
      return 2'b01;
    else if (wb_we && (wb_rd != 4'd0) && (wb_rd == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign load_use = exValid && exIsLoad && exRegWrite && (exRd != 4'd0) && idValid &&
                    ((idUsesRq && (idRq == exRd)) || (idUsesRs && (idRs == exRd)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stallIF  = 1'b0;
    stallID  = 1'b0;
    stallEX  = 1'b0;
    bubbleEX = 1'b0;
    flushID  = 1'b0;
    aluBusy  = 1'b0;
    aluDone  = 1'b0;
    fwdA     = fwd_sel(exRq, memRd, memRegWrite, wbRd, wbRegWrite);
    fwdB     = fwd_sel(exRs, memRd, memRegWrite, wbRd, wbRegWrite);

    case (state_q)
      RUN: begin
        if (exFlush) begin
          flushID  = 1'b1;
          bubbleEX = 1'b1;
          state_d  = REDIRECT;
        end else if (exValid && exMultiCycle) begin
          stallIF = 1'b1;
          stallID = 1'b1;
          stallEX = 1'b1;
          aluBusy = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = MULTI;
        end else if (load_use) begin
          stallIF  = 1'b1;
          stallID  = 1'b1;
          bubbleEX = 1'b1;
        end
      end
      MULTI: begin
        stallIF = 1'b1;
        stallID = 1'b1;
        aluBusy = 1'b1;
        if (cnt_q == 4'd0) begin
          aluDone = 1'b1;
          state_d = RUN;
        end else begin
          stallEX = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        flushID  = 1'b1;
        bubbleEX = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase

    // Reset is asynchronous, so outputs are quiet for the whole time rst_n is low.
    if (!rst_n) begin
      stallIF  = 1'b0;
      stallID  = 1'b0;
      stallEX  = 1'b0;
      bubbleEX = 1'b0;
      flushID  = 1'b0;
      aluBusy  = 1'b0;
      aluDone  = 1'b0;
      fwdA     = 2'b00;
      fwdB     = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       idValid, idUsesRq, idUsesRs;
  logic [3:0] idRq, idRs;
  logic       exValid, exRegWrite, exIsLoad, exMultiCycle, exFlush;
  logic [3:0] exRq, exRs, exRd;
  logic [3:0] memRd, wbRd;
  logic       memRegWrite, wbRegWrite;
  logic       stallIF, stallID, stallEX, bubbleEX, flushID, aluBusy, aluDone;
  logic [1:0] fwdA, fwdB;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [10:0] e;
  } exp_t;
  exp_t sb[$];

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .idValid(idValid), .idRq(idRq), .idRs(idRs), .idUsesRq(idUsesRq), .idUsesRs(idUsesRs),
    .exValid(exValid), .exRq(exRq), .exRs(exRs), .exRd(exRd),
    .exRegWrite(exRegWrite), .exIsLoad(exIsLoad), .exMultiCycle(exMultiCycle),
    .exFlush(exFlush), .memRd(memRd), .wbRd(wbRd),
    .memRegWrite(memRegWrite), .wbRegWrite(wbRegWrite),
    .stallIF(stallIF), .stallID(stallID), .stallEX(stallEX), .bubbleEX(bubbleEX),
    .flushID(flushID), .fwdA(fwdA), .fwdB(fwdB), .aluBusy(aluBusy), .aluDone(aluDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected word: {stallIF, stallID, stallEX, bubbleEX, flushID, aluBusy, aluDone, fwdA, fwdB}
  function automatic logic [10:0] ex(input logic sif, input logic sid, input logic sex,
                                     input logic bex, input logic fid, input logic busy,
                                     input logic done, input logic [1:0] fa, input logic [1:0] fb);
    return {sif, sid, sex, bex, fid, busy, done, fa, fb};
  endfunction

  localparam logic [10:0] E0    = 11'b0;
  localparam logic [10:0] EMUL  = 11'b111_0_0_1_0_00_00;
  localparam logic [10:0] EDONE = 11'b110_0_0_1_1_00_00;
  localparam logic [10:0] ELU   = 11'b110_1_0_0_0_00_00;
  localparam logic [10:0] EFL   = 11'b000_1_1_0_0_00_00;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t t;
      logic [10:0] got;
      t   = sb.pop_front();
      got = {stallIF, stallID, stallEX, bubbleEX, flushID, aluBusy, aluDone, fwdA, fwdB};
      total++;
      if (got !== t.e) begin
        bad++;
        $display("FAIL %s: got=%b want=%b (sif sid sex bex fid busy done fa fb)", t.nm, got, t.e);
      end
    end
  end

  task automatic step(input string nm, input logic [10:0] e);
    exp_t t;
    t.nm = nm;
    t.e  = e;
    sb.push_back(t);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    idValid = 0; idRq = 0; idRs = 0; idUsesRq = 0; idUsesRs = 0;
    exValid = 0; exRq = 0; exRs = 0; exRd = 0;
    exRegWrite = 0; exIsLoad = 0; exMultiCycle = 0; exFlush = 0;
    memRd = 0; wbRd = 0; memRegWrite = 0; wbRegWrite = 0;
  endtask

  task automatic set_load_use(input logic [3:0] rd);
    exValid = 1; exIsLoad = 1; exRegWrite = 1; exRd = rd;
    idValid = 1; idRs = 5; idUsesRs = 1;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    // Active inputs while in reset must not reach the outputs.
    exValid = 1; exFlush = 1; exMultiCycle = 1;
    exRq = 3; memRd = 3; memRegWrite = 1;
    step("reset_quiet", E0);
    idle_in();
    step("reset_hold", E0);
    rst_n = 1'b1;
    step("idle_after_reset", E0);

    // Multi-cycle op, MUL_LAT=4; exFlush during MULTI is ignored.
    exValid = 1; exMultiCycle = 1;
    step("mul_c0", EMUL);
    step("mul_c1", EMUL);
    exFlush = 1;
    step("mul_c2_flush_ignored", EMUL);
    exFlush = 0;
    step("mul_c3_done", EDONE);
    idle_in();
    step("mul_after", E0);

    // Reset mid-MULTI with cnt=2 aborts immediately.
    exValid = 1; exMultiCycle = 1;
    step("mul2_c0", EMUL);
    idle_in();
    rst_n = 1'b0;
    exRq = 3; memRd = 3; memRegWrite = 1;
    step("reset_mid_multi", E0);
    idle_in();
    rst_n = 1'b1;
    step("after_abort_no_done", E0);
    exValid = 1; exMultiCycle = 1;
    step("mul3_c0", EMUL);
    step("mul3_c1", EMUL);
    step("mul3_c2", EMUL);
    step("mul3_c3_done", EDONE);
    idle_in();

    // Load-use, including a back-to-back pair and the rq path.
    set_load_use(5);
    step("lu_rs", ELU);
    step("lu_pair_second", ELU);
    set_load_use(0);
    step("lu_rd0_none", E0);
    set_load_use(7);
    idRq = 7; idUsesRq = 1; idUsesRs = 0;
    step("lu_rq", ELU);
    idUsesRq = 0;
    step("lu_rq_unused", E0);
    idle_in();

    // Taken branch: flush cycle then REDIRECT; load-use suppressed in REDIRECT.
    exFlush = 1;
    step("br_flush", EFL);
    exFlush = 0;
    set_load_use(5);
    step("br_redirect_lu_suppressed", EFL);
    step("br_back_to_run_lu", ELU);
    idle_in();

    // Flush priority over load-use and over multi-cycle.
    set_load_use(5);
    exFlush = 1;
    step("prio_flush_over_lu", EFL);
    idle_in();
    step("prio_redirect", EFL);
    exValid = 1; exMultiCycle = 1; exFlush = 1;
    step("prio_flush_over_mul", EFL);
    idle_in();
    step("prio_mul_redirect", EFL);
    step("prio_idle", E0);

    // Forwarding: MEM beats WB, register 0 never forwarded.
    exRq = 3; exRs = 3; memRd = 3; memRegWrite = 1; wbRd = 3; wbRegWrite = 1;
    step("fwd_mem", ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01));
    memRegWrite = 0;
    step("fwd_wb", ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10));
    exRq = 0;
    step("fwd_a_r0_b_wb", ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10));
    exRq = 0; exRs = 0; memRd = 0; memRegWrite = 1; wbRd = 0;
    step("fwd_zero_dest", E0);
    exRq = 6; exRs = 9; memRd = 9; memRegWrite = 1; wbRd = 6; wbRegWrite = 1;
    step("fwd_split", ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01));
    idle_in();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the execute stage. It sequences the ALU datapath across multi-cycle operations and squashes wrong-path instructions after a taken branch or jump. It inserts load-use bubbles and drives the operand-forwarding selects for the two ALU source muxes. It sits beside the execute stage and drives the stall, flush and bubble enables of the IF/ID and ID/EX pipeline registers.

## Interface
- MUL_LAT, 4: total EX cycles taken by a multi-cycle ALU op; legal range 2..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- idValid  in  1  ID stage holds a valid instruction
- idRq, idRs  in  4  source register indices of the ID instruction
- idUsesRq, idUsesRs  in  1  ID instruction reads that source
- exValid  in  1  EX stage holds a valid instruction
- exRq, exRs  in  4  source indices of the EX instruction
- exRd  in  4  destination of the EX instruction
- exRegWrite, exIsLoad, exMultiCycle  in  1  EX instruction attributes
- exFlush  in  1  taken jump/branch resolved in EX
- memRd, wbRd  in  4  destinations in MEM and WB
- memRegWrite, wbRegWrite  in  1  MEM/WB will write memRd/wbRd
- stallIF, stallID  out  1  hold PC and the IF/ID register
- stallEX  out  1  hold the ID/EX register and ALU inputs
- bubbleEX  out  1  load a NOP into ID/EX next edge
- flushID  out  1  load a NOP into IF/ID next edge
- fwdA, fwdB  out  2  ALU operand select for exRq/exRs: 00 register file, 01 MEM result, 10 WB result
- aluBusy  out  1  multi-cycle op in progress
- aluDone  out  1  last cycle of a multi-cycle op

## Operation
- FSM states: RUN, MULTI, REDIRECT. A 4-bit down-counter `cnt` is used in MULTI.
- RUN:
  - If exFlush: assert flushID and bubbleEX, no stalls, next state REDIRECT. Flush has priority over load-use and multi-cycle.
  - Else if exValid & exMultiCycle: assert stallIF, stallID, stallEX and aluBusy. Load cnt = MUL_LAT-2. Next state MULTI.
  - Else if load-use: assert stallIF, stallID and bubbleEX for that cycle. State stays RUN.
  - Load-use condition: exValid & exIsLoad & exRegWrite & exRd!=0 & idValid & ((idUsesRq & idRq==exRd) | (idUsesRs & idRs==exRd)).
- MULTI:
  - stallIF, stallID, stallEX and aluBusy asserted every cycle.
  - cnt decrements each cycle.
  - When cnt==0: aluDone=1, stallEX=0 (the result advances), stallIF/stallID remain 1 for that cycle, next state RUN.
  - exFlush is ignored in MULTI; a multi-cycle op is never a branch.
- REDIRECT (exactly 1 cycle):
  - flushID=1 squashes the instruction fetched from the stale PC.
  - bubbleEX=1; no stalls. Load-use and multi-cycle detection are suppressed.
  - Next state RUN.
- Forwarding (combinational, all states):
  - fwdA=01 if memRegWrite & memRd!=0 & memRd==exRq.
  - Else fwdA=10 if wbRegWrite & wbRd!=0 & wbRd==exRq.
  - Else fwdA=00.
  - fwdB is identical, using exRs. MEM beats WB. Register 0 is never forwarded.
- The FSM leaves RUN only on a rising clk edge.

## Timing
- Control outputs are combinational from state, cnt and inputs. State and cnt are registered.
- Reset: rst_n low takes effect immediately. State=RUN, cnt=0. stallIF, stallID, stallEX, bubbleEX, flushID, aluBusy and aluDone are all 0 while rst_n is low. fwdA/fwdB are 00 while rst_n is low.
- Reset mid-MULTI or mid-REDIRECT aborts to RUN with no aluDone pulse.
- Multi-cycle op occupancy: exactly MUL_LAT cycles in EX, i.e. 1 RUN cycle plus MUL_LAT-1 MULTI cycles. aluDone is high on the last of these.
- Load-use costs exactly 1 bubble. A back-to-back load-use pair costs 1 bubble each.
- Taken branch costs 2 squashed slots: the flush cycle plus the REDIRECT cycle.
- Simultaneous events:
  - exFlush with load-use condition true: flush wins; no stall.
  - exFlush with exMultiCycle: flush wins; illegal per ISA.

## Test plan
- Reset: drive rst_n=0 mid-MULTI with cnt=2 -> all control outputs 0 immediately. After release, state RUN and the next exMultiCycle starts a full MUL_LAT sequence.
- Multi-cycle, MUL_LAT=4: exValid=1, exMultiCycle=1 at cycle 0 -> stallEX=1 for cycles 0-2, 0 at cycle 3. aluDone=1 only at cycle 3. aluBusy=1 for cycles 0-3. stallIF=1 for cycles 0-3.
- Load-use: exIsLoad=1, exRd=5, idRs=5, idUsesRs=1 -> stallIF=stallID=bubbleEX=1 for one cycle. Repeat with exRd=0 -> no stall.
- Branch: exFlush=1 in RUN -> flushID=1 and bubbleEX=1 for 2 consecutive cycles, stalls 0. A load-use condition during the second cycle produces no stall.
- Forwarding: exRq=3, memRd=3, memRegWrite=1, wbRd=3, wbRegWrite=1 -> fwdA=01. With memRegWrite=0 -> fwdA=10. With exRq=0 -> fwdA=00.
- Priority: exFlush=1 with the load-use condition true -> flushID=1, stallIF=0, next state REDIRECT.
